color_stream_to_board: RTL and testbench

//   Inverse of the board-to-color mapping: rebuilds the 12x10 board of 4-bit piece

---
 rtl/color_stream_to_board.sv | 140 ++++++++++++++
 tb/tb_color_stream_to_board.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/color_stream_to_board.sv
// Rebuilds the ROWSxCOLS board of 4-bit piece codes from a row-major stream of
// 8-bit color cells; a shadow board is committed atomically once the frame is complete.
module color_stream_to_board #(
  parameter int unsigned ROWS = 12,
  parameter int unsigned COLS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic                 pix_sof,
  input  logic [7:0]           pix_data,
  output logic                 pix_ready,
  output logic [COLS*4-1:0]    board [0:ROWS-1],
  output logic                 frame_valid,
  output logic [7:0]           bad_count
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BW = COLS * 4;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [BW-1:0]      shadow_q [0:ROWS-1];
  logic [BW-1:0]      shadow_d [0:ROWS-1];
  logic [BW-1:0]      board_q  [0:ROWS-1];
  logic [BW-1:0]      board_d  [0:ROWS-1];
  logic [7:0]         sbad_q, sbad_d;
  logic [7:0]         bad_count_q, bad_count_d;
  logic               frame_valid_q, frame_valid_d;

  logic               xfer;
  logic [3:0]         code;
  logic               unmapped;
  logic [7:0]         sbad_inc;
  logic [CW+1:0]      cbase;

  // Exact-match color decode; anything unlisted is counted as unmapped
  always_comb begin
    unmapped = 1'b0;
    case (pix_data)
      8'hF0:   code = 4'd1;
      8'hF9:   code = 4'd2;
      8'h14:   code = 4'd3;
      8'h7F:   code = 4'd4;
      8'h4F:   code = 4'd5;
      8'h8F:   code = 4'd6;
      8'hF3:   code = 4'd7;
      8'hC0:   code = 4'd8;
      8'h00:   code = 4'd0;
      default: begin
        code     = 4'd0;
        unmapped = 1'b1;
      end
    endcase
  end

  assign pix_ready = !rst && (state_q != COMMIT);
  assign xfer      = pix_valid && pix_ready;
  assign sbad_inc  = (unmapped && (sbad_q != 8'hFF)) ? sbad_q + 8'd1 : sbad_q;
  assign cbase     = {col_q, 2'b00};

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    shadow_d      = shadow_q;
    board_d       = board_q;
    sbad_d        = sbad_q;
    bad_count_d   = bad_count_q;
    frame_valid_d = 1'b0;

    case (state_q)
      IDLE, RECV: begin
        if (xfer && pix_sof) begin
          shadow_d[0][3:0] = code;
          row_d            = '0;
          col_d            = CW'(1);
          sbad_d           = unmapped ? 8'd1 : 8'd0;
          state_d          = RECV;
        end else if (xfer && (state_q == RECV)) begin
          shadow_d[row_q][cbase +: 4] = code;
          sbad_d                      = sbad_inc;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d   = '0;
              state_d = COMMIT;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      COMMIT: begin
        board_d       = shadow_q;
        bad_count_d   = sbad_q;
        frame_valid_d = 1'b1;
        row_d         = '0;
        col_d         = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      sbad_q        <= '0;
      bad_count_q   <= '0;
      frame_valid_q <= 1'b0;
      for (int i = 0; i < int'(ROWS); i++) begin
        shadow_q[i] <= '0;
        board_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      sbad_q        <= sbad_d;
      bad_count_q   <= bad_count_d;
      frame_valid_q <= frame_valid_d;
      shadow_q      <= shadow_d;
      board_q       <= board_d;
    end
  end

  assign board       = board_q;
  assign frame_valid = frame_valid_q;
  assign bad_count   = bad_count_q;

endmodule

// File: tb/tb_color_stream_to_board.sv
// Bench for color_stream_to_board: a cell-list reference model checked every cycle,
// plus literal expectations after each directed frame.
module tb_color_stream_to_board;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_ready;
  logic [39:0] board [0:11];
  logic        frame_valid;
  logic [7:0]  bad_count;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;

  color_stream_to_board dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .board(board),
    .frame_valid(frame_valid), .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  // Reference model: cells as a flat row-major list of 120 codes
  int   m_cells [120];
  int   e_cells [120];
  int   m_idx = 0;
  bit   m_active = 0;
  bit   m_commit = 0;
  int   m_bad = 0;
  int   e_bad = 0;
  bit   e_fv = 0;

  function automatic int color_code(input logic [7:0] c);
    case (c)
      8'hF0: return 1;  8'hF9: return 2;  8'h14: return 3;
      8'h7F: return 4;  8'h4F: return 5;  8'h8F: return 6;
      8'hF3: return 7;  8'hC0: return 8;  8'h00: return 0;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    int c;
    if (rst) begin
      for (int k = 0; k < 120; k++) begin m_cells[k] = 0; e_cells[k] = 0; end
      m_idx = 0; m_active = 0; m_commit = 0; m_bad = 0; e_bad = 0; e_fv = 0;
    end else begin
      e_fv = 0;
      if (m_commit) begin
        e_cells = m_cells;
        e_bad = m_bad;
        e_fv = 1;
        m_commit = 0;
      end else if (pix_valid) begin
        c = color_code(pix_data);
        if (pix_sof) begin
          m_cells[0] = (c < 0) ? 0 : c;
          m_bad = (c < 0) ? 1 : 0;
          m_idx = 1;
          m_active = 1;
        end else if (m_active) begin
          m_cells[m_idx] = (c < 0) ? 0 : c;
          if (c < 0 && m_bad < 255) m_bad++;
          m_idx++;
          if (m_idx == 120) begin m_active = 0; m_commit = 1; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic [479:0] got_flat, exp_flat;
    for (int r = 0; r < 12; r++) begin
      got_flat[r*40 +: 40] = board[r];
      for (int j = 0; j < 10; j++) exp_flat[r*40 + j*4 +: 4] = 4'(e_cells[r*10 + j]);
    end
    n_cmp++;
    if (got_flat !== exp_flat) begin
      n_bad++;
      $display("FAIL board got=%h exp=%h t=%0t", got_flat, exp_flat, $time);
    end
    check("frame_valid", 64'(frame_valid), 64'(e_fv));
    check("bad_count", 64'(bad_count), 64'(e_bad));
    check("pix_ready", 64'(pix_ready), 64'(!rst && !m_commit));
    if (frame_valid === 1'b1) fv_cnt++;
  end

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [7:0] d, input logic sof);
    logic acc;
    int guard;
    pix_valid = 1'b1;
    pix_sof = sof;
    pix_data = d;
    guard = 0;
    do begin
      acc = pix_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check("beat_timeout", 64'(acc), 64'd1);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input bit gaps);
    for (int i = 0; i < 120; i++) begin
      beat(d, i == 0);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    int fv0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    // Test 1: reset values
    check("t1_ready", 64'(pix_ready), 64'd1);
    check("t1_row0", 64'(board[0]), 64'h0);
    check("t1_bad", 64'(bad_count), 64'd0);
    @(posedge clk); #1;

    // Test 2: contiguous F0 frame
    fv0 = fv_cnt;
    frame(8'hF0, 0);
    idle(3);
    check("t2_row0", 64'(board[0]), 64'h1111111111);
    check("t2_row11", 64'(board[11]), 64'h1111111111);
    check("t2_bad", 64'(bad_count), 64'd0);
    check("t2_fv", 64'(fv_cnt - fv0), 64'd1);

    // Test 3: unmapped first cell, C0 final cell
    fv0 = fv_cnt;
    for (int i = 0; i < 120; i++)
      beat((i == 0) ? 8'hAA : (i == 119) ? 8'hC0 : 8'h00, i == 0);
    idle(3);
    check("t3_c00", 64'(board[0][3:0]), 64'd0);
    check("t3_c119", 64'(board[11][39:36]), 64'd8);
    check("t3_row11", 64'(board[11]), 64'h8000000000);
    check("t3_row5", 64'(board[5]), 64'h0);
    check("t3_bad", 64'(bad_count), 64'd1);
    check("t3_fv", 64'(fv_cnt - fv0), 64'd1);

    // Test 4: F0 frame with random gaps
    fv0 = fv_cnt;
    frame(8'hF0, 1);
    idle(3);
    check("t4_row7", 64'(board[7]), 64'h1111111111);
    check("t4_bad", 64'(bad_count), 64'd0);
    check("t4_fv", 64'(fv_cnt - fv0), 64'd1);

    // Test 5: restart mid-frame with a new sof
    fv0 = fv_cnt;
    for (int i = 0; i < 50; i++) beat(8'h14, i == 0);
    frame(8'h7F, 0);
    idle(3);
    check("t5_row0", 64'(board[0]), 64'h4444444444);
    check("t5_row11", 64'(board[11]), 64'h4444444444);
    check("t5_fv", 64'(fv_cnt - fv0), 64'd1);

    // Test 6: reset mid-frame, sof-less beats dropped, then normal frame
    frame(8'hF3, 0);
    idle(3);
    check("t6_f3", 64'(board[4]), 64'h7777777777);
    fv0 = fv_cnt;
    for (int i = 0; i < 60; i++) beat(8'hF9, i == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) beat(8'h4F, 0);
    idle(3);
    check("t6_zero", 64'(board[4]), 64'h0);
    check("t6_nofv", 64'(fv_cnt - fv0), 64'd0);
    frame(8'hF9, 0);
    idle(3);
    check("t6_row3", 64'(board[3]), 64'h2222222222);
    check("t6_fv", 64'(fv_cnt - fv0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
